servo_ramp_ctrl: RTL and testbench
==================================

Name: servo_ramp_ctrl

Overview:
Memory-mapped motion scheduler between the processor's dmem bus and the three servo PWM controllers. The processor writes per-channel target duty cycles and a global slew step. The block then moves each channel's output duty toward its target by at most one step per scheduler tick, servicing channels round-robin, one per clock. Busy status is readable back over the same bus, so software can wait for motion to complete instead of using fixed delay loops.

Parameters:
DUTY_W, 10, width of each duty value.
TICK_DIV, 500000, clock cycles per scheduler tick (10 ms at 50 MHz); must be ≥ 4.
MIN_DUTY, 0, lower clamp applied to written targets.
MAX_DUTY, 1023, upper clamp applied to written targets.
CENTER_DUTY, 512, reset value of every target and output duty.
DEFAULT_STEP, 4, reset value of the step register.
TGT_ADDR0, 12'd11, target address for ch0; ch1 = +1, ch2 = +2.
STEP_ADDR, 12'd20, step register address (write only).
STATUS_ADDR, 12'd21, status register address (read only).

Ports:
clock  in  1  system clock (50 MHz domain)
reset  in  1  synchronous, active-high
mem_addr  in  12  dmem address (memAddr[11:0])
mem_wren  in  1  dmem write enable
mem_wdata  in  32  dmem write data
rd_hit  out  1  high combinationally when mem_addr == STATUS_ADDR
rd_data  out  32  {29'b0, busy}; valid whenever rd_hit is high
duty_out  out  3*DUTY_W  {ch2, ch1, ch0} current duty, registered, feeds the ServoControllers
busy  out  3  busy[i] = (cur[i] != tgt[i])
tick_out  out  1  one-cycle pulse at each scheduler tick (debug/LED)

Behaviour:
Reset (clock and reset are the single clock and synchronous active-high reset already decided):
- cur[i] = tgt[i] = CENTER_DUTY; step = DEFAULT_STEP.
- Tick counter = 0; FSM = IDLE; tick_out = 0; busy = 0.
- Reset asserted mid-ramp aborts the motion: all state returns to the values above on the next edge.

Writes, one-cycle effect at the edge where mem_wren = 1:
- Target write: addr == TGT_ADDR0 + i, i in 0..2. tgt[i] <= clamp(mem_wdata[DUTY_W-1:0], MIN_DUTY, MAX_DUTY). Upper data bits are ignored.
- Step write: addr == STEP_ADDR. step <= mem_wdata[DUTY_W-1:0].
- Writes to STATUS_ADDR or any other address are ignored.

Tick generator:
- Free-running counter 0..TICK_DIV-1.
- tick asserts for one cycle when the counter equals TICK_DIV-1; the counter wraps to 0 on that cycle.
- tick_out is tick registered, so it lags tick by 1 cycle.

FSM states: IDLE, UPD0, UPD1, UPD2.
- IDLE -> UPD0 on tick.
- UPD0 -> UPD1 -> UPD2 -> IDLE unconditionally, one cycle each.
- In UPDk, cur[k] is updated at the end of the cycle:
  - cur < tgt: cur <= min(cur + step, tgt). The sum is computed in DUTY_W+1 bits, so no wrap.
  - cur > tgt: cur <= max(cur - step, tgt). Computed without underflow.
  - step == 0: cur <= tgt (snap).
  - cur == tgt: no change.
- Latency: a channel moves at most once per tick. ch0 updates 1 cycle after tick, ch1 2 cycles after, ch2 3 cycles after.
- Simultaneous target write and update of the same channel: the update uses the pre-write tgt. The new target is tracked from the next tick. Same rule applies to step writes.
- A tick cannot occur while the FSM is not in IDLE (TICK_DIV ≥ 4). The bench asserts this.

Read path:
- rd_hit and rd_data are purely combinational from mem_addr and registered state.
- The integrating wrapper muxes rd_data into q_dmem when rd_hit is high.

Decomposition:
Shared package servo_pkg holds:
- DUTY_W
- default address constants (TGT_ADDR0, STEP_ADDR, STATUS_ADDR)
- FSM state encoding (2-bit IDLE/UPD0/UPD1/UPD2)
- a clamp function

One sub-module, servo_tick_gen: parameter TICK_DIV, ports clock, reset, tick. The slew arithmetic stays inline.

Test Plan:
All scenarios use TICK_DIV = 4.
- Reset: assert reset 2 cycles -> duty_out = {512, 512, 512}, busy = 0, rd_data at addr 21 = 0, tick_out = 0.
- Ramp up: step = 4, write 520 to addr 11 -> busy[0] = 1 next cycle; cur0 = 516 after the 1st tick's UPD0, 520 after the 2nd; busy[0] = 0 then; ch1 and ch2 unchanged.
- Partial final step and down-ramp: step = 10, write 505 to addr 12 -> cur1 = 505 after 1 tick (512 - 10 would undershoot, so it is clamped to the target); then write 1023 to addr 13, step = 0 -> cur2 = 1023 after 1 tick.
- Clamp: MIN_DUTY = 50, MAX_DUTY = 100, write 32'h0000_0FFF to addr 11 -> tgt0 = 100; write 3 -> tgt0 = 50.
- Collision: write tgt0 = 600 in the exact UPD0 cycle while cur0 = tgt0 = 512 -> cur0 stays 512 that tick; moves to 516 on the next tick.
- Reset mid-ramp: reset while cur0 = 540 ramping to 700 -> next edge cur0 = tgt0 = 512, FSM IDLE, counter 0; read at addr 21 returns 0.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared constants, FSM encoding and target clamp for the servo ramp scheduler.
package servo_pkg;

    localparam int unsigned DUTY_W = 10;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NUM_CH = 3;

    localparam logic [ADDR_W-1:0] TGT_ADDR0_DEF   = 12'd11;
    localparam logic [ADDR_W-1:0] STEP_ADDR_DEF   = 12'd20;
    localparam logic [ADDR_W-1:0] STATUS_ADDR_DEF = 12'd21;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UPD0 = 2'd1,
        UPD1 = 2'd2,
        UPD2 = 2'd3
    } servo_state_e;

    function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] val,
                                                     input logic [DUTY_W-1:0] lo,
                                                     input logic [DUTY_W-1:0] hi);
        if (val < lo) return lo;
        if (val > hi) return hi;
        return val;
    endfunction

endpackage

// File: rtl/servo_ramp_ctrl_if.sv
// Processor dmem bus as seen by the servo scheduler: write side plus status read-back.
interface servo_ramp_ctrl_if;
    import servo_pkg::*;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_wdata;
    logic              rd_hit;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output mem_addr, mem_wren, mem_wdata,
        input  rd_hit, rd_data
    );

    modport slave (
        input  mem_addr, mem_wren, mem_wdata,
        output rd_hit, rd_data
    );

endinterface

// File: rtl/servo_tick_gen.sv
// Free-running divider producing a one-cycle scheduler tick every TICK_DIV clocks.
module servo_tick_gen #(
    parameter int unsigned TICK_DIV = 500000
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == CNT_MAX);

endmodule

// File: rtl/servo_ramp_ctrl.sv
// Memory-mapped slew scheduler: ramps three servo duties toward their targets,
// one channel per clock after each tick, with busy status readable over dmem.
module servo_ramp_ctrl
    import servo_pkg::*;
#(
    parameter int unsigned       TICK_DIV     = 500000,
    parameter int unsigned       MIN_DUTY     = 0,
    parameter int unsigned       MAX_DUTY     = 1023,
    parameter int unsigned       CENTER_DUTY  = 512,
    parameter int unsigned       DEFAULT_STEP = 4,
    parameter logic [ADDR_W-1:0] TGT_ADDR0    = TGT_ADDR0_DEF,
    parameter logic [ADDR_W-1:0] STEP_ADDR    = STEP_ADDR_DEF,
    parameter logic [ADDR_W-1:0] STATUS_ADDR  = STATUS_ADDR_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    servo_ramp_ctrl_if.slave           bus,
    output logic [NUM_CH*DUTY_W-1:0]   duty_out,
    output logic [NUM_CH-1:0]          busy,
    output logic                       tick_out
);

    servo_state_e      state;
    servo_state_e      state_nxt;
    logic              tick;
    logic              upd_en;
    logic [1:0]        upd_ch;
    logic [DUTY_W-1:0] cur [NUM_CH];
    logic [DUTY_W-1:0] tgt [NUM_CH];
    logic [DUTY_W-1:0] step;

    logic [NUM_CH-1:0] tgt_wr;
    logic              step_wr;
    logic [DUTY_W-1:0] wr_duty;
    logic [DUTY_W-1:0] wr_clamped;
    logic              unused_wdata_hi;

    logic [DUTY_W-1:0] sel_cur;
    logic [DUTY_W-1:0] sel_tgt;
    logic [DUTY_W:0]   up_sum;
    logic [DUTY_W-1:0] down_gap;
    logic [DUTY_W-1:0] slew_nxt;

    servo_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    // Register write decode; only the low DUTY_W data bits are meaningful.
    always_comb begin
        wr_duty    = bus.mem_wdata[DUTY_W-1:0];
        wr_clamped = clamp_duty(wr_duty, DUTY_W'(MIN_DUTY), DUTY_W'(MAX_DUTY));
        step_wr    = bus.mem_wren && (bus.mem_addr == STEP_ADDR);
        for (int i = 0; i < NUM_CH; i++) begin
            tgt_wr[i] = bus.mem_wren && (bus.mem_addr == TGT_ADDR0 + ADDR_W'(i));
        end
    end

    assign unused_wdata_hi = ^bus.mem_wdata[DATA_W-1:DUTY_W];

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tick) state_nxt = UPD0;
            UPD0:    state_nxt = UPD1;
            UPD1:    state_nxt = UPD2;
            UPD2:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        upd_en = 1'b0;
        upd_ch = 2'd0;
        case (state)
            UPD0:    begin upd_en = 1'b1; upd_ch = 2'd0; end
            UPD1:    begin upd_en = 1'b1; upd_ch = 2'd1; end
            UPD2:    begin upd_en = 1'b1; upd_ch = 2'd2; end
            default: begin upd_en = 1'b0; upd_ch = 2'd0; end
        endcase
    end

    // One slew step for the serviced channel; both directions saturate at the target.
    always_comb begin
        sel_cur  = cur[upd_ch];
        sel_tgt  = tgt[upd_ch];
        up_sum   = {1'b0, sel_cur} + {1'b0, step};
        down_gap = sel_cur - sel_tgt;
        slew_nxt = sel_cur;
        if (step == '0) begin
            slew_nxt = sel_tgt;
        end else if (sel_cur < sel_tgt) begin
            slew_nxt = (up_sum >= {1'b0, sel_tgt}) ? sel_tgt : up_sum[DUTY_W-1:0];
        end else if (sel_cur > sel_tgt) begin
            slew_nxt = (down_gap <= step) ? sel_tgt : sel_cur - step;
        end
    end

    // The update reads pre-write tgt/step, so a colliding write takes effect next tick.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cur[i] <= DUTY_W'(CENTER_DUTY);
                tgt[i] <= DUTY_W'(CENTER_DUTY);
            end
            step     <= DUTY_W'(DEFAULT_STEP);
            tick_out <= 1'b0;
        end else begin
            tick_out <= tick;
            if (step_wr) step <= wr_duty;
            for (int i = 0; i < NUM_CH; i++) begin
                if (tgt_wr[i]) tgt[i] <= wr_clamped;
                if (upd_en && (upd_ch == 2'(i))) cur[i] <= slew_nxt;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            busy[i] = (cur[i] != tgt[i]);
        end
    end

    assign duty_out    = {cur[2], cur[1], cur[0]};
    assign bus.rd_hit  = (bus.mem_addr == STATUS_ADDR);
    assign bus.rd_data = {{(DATA_W-NUM_CH){1'b0}}, busy};

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Bench for servo_ramp_ctrl: two instances (full-range and narrow clamp) share one bus,
// checked every cycle against a tick-schedule model plus directed literal expectations.
module tb_servo_ramp_ctrl;
    import servo_pkg::*;

    localparam int unsigned TD = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] addr;
    logic        wren;
    logic [31:0] wdata;

    logic [29:0] duty_a, duty_b;
    logic [2:0]  busy_a, busy_b;
    logic        tick_out_a, tick_out_b;

    int checks   = 0;
    int failures = 0;

    servo_ramp_ctrl_if bus_a ();
    servo_ramp_ctrl_if bus_b ();

    assign bus_a.mem_addr  = addr;
    assign bus_a.mem_wren  = wren;
    assign bus_a.mem_wdata = wdata;
    assign bus_b.mem_addr  = addr;
    assign bus_b.mem_wren  = wren;
    assign bus_b.mem_wdata = wdata;

    servo_ramp_ctrl #(.TICK_DIV(TD)) dut_a (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus_a),
        .duty_out (duty_a),
        .busy     (busy_a),
        .tick_out (tick_out_a)
    );

    servo_ramp_ctrl #(.TICK_DIV(TD), .MIN_DUTY(50), .MAX_DUTY(100)) dut_b (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus_b),
        .duty_out (duty_b),
        .busy     (busy_b),
        .tick_out (tick_out_b)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Model: tick on every cycle n with n % TD == TD-1 (n counted from reset release);
    // channel k moves at the end of cycle n+1+k, reading the pre-write target and step.
    int cur_m  [2][3];
    int tgt_m  [2][3];
    int step_m [2];
    int n_cyc;
    bit tick_out_m;
    bit model_valid = 1'b0;

    function automatic int lo_of(input int d);
        return (d == 0) ? 0 : 50;
    endfunction

    function automatic int hi_of(input int d);
        return (d == 0) ? 1023 : 100;
    endfunction

    function automatic int slew(input int c, input int t, input int s);
        if (s == 0) return t;
        if (c < t) return (c + s > t) ? t : c + s;
        if (c > t) return (c - s < t) ? t : c - s;
        return c;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < 3; k++) begin
                    cur_m[d][k] = 512;
                    tgt_m[d][k] = 512;
                end
                step_m[d] = 4;
            end
            n_cyc       = 0;
            tick_out_m  = 1'b0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            for (int k = 0; k < 3; k++) begin
                if ((n_cyc - 1 - k) >= 0 && ((n_cyc - 1 - k) % TD) == TD - 1) begin
                    for (int d = 0; d < 2; d++) cur_m[d][k] = slew(cur_m[d][k], tgt_m[d][k], step_m[d]);
                end
            end
            if (wren) begin
                for (int d = 0; d < 2; d++) begin
                    int v;
                    v = int'(wdata[9:0]);
                    if (addr >= 12'd11 && addr <= 12'd13) begin
                        tgt_m[d][addr - 12'd11] = (v < lo_of(d)) ? lo_of(d) : ((v > hi_of(d)) ? hi_of(d) : v);
                    end
                    if (addr == 12'd20) step_m[d] = v;
                end
            end
            tick_out_m = ((n_cyc % TD) == TD - 1);
            n_cyc++;
        end
    end

    function automatic logic [29:0] duty_exp(input int d);
        logic [29:0] r;
        for (int k = 0; k < 3; k++) r[k*10 +: 10] = 10'(cur_m[d][k]);
        return r;
    endfunction

    function automatic logic [2:0] busy_exp(input int d);
        logic [2:0] r;
        for (int k = 0; k < 3; k++) r[k] = (cur_m[d][k] != tgt_m[d][k]);
        return r;
    endfunction

    // Cycle-by-cycle comparison, sampled 1 time unit after the active edge.
    always @(posedge clock) begin
        #1;
        if (model_valid) begin
            chk("duty_a", 64'(duty_a), 64'(duty_exp(0)));
            chk("duty_b", 64'(duty_b), 64'(duty_exp(1)));
            chk("busy_a", 64'(busy_a), 64'(busy_exp(0)));
            chk("busy_b", 64'(busy_b), 64'(busy_exp(1)));
            chk("tick_out_a", 64'(tick_out_a), 64'(tick_out_m));
            chk("tick_out_b", 64'(tick_out_b), 64'(tick_out_m));
            chk("rd_hit_a", 64'(bus_a.rd_hit), 64'(addr == 12'd21));
            if (bus_a.rd_hit) chk("rd_data_a", 64'(bus_a.rd_data), 64'({29'd0, busy_exp(0)}));
            if (bus_b.rd_hit) chk("rd_data_b", 64'(bus_b.rd_data), 64'({29'd0, busy_exp(1)}));
            if (dut_a.tick) chk("tick_only_in_idle", 64'(dut_a.state), 64'(IDLE));
        end
    end

    task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wren  = 1'b1;
        @(negedge clock);
        wren  = 1'b0;
        addr  = 12'd21;
        wdata = 32'd0;
    endtask

    // Leaves the bench at the negedge inside the next cycle in which tick_out is high.
    task automatic sync_tick();
        int w = 0;
        while (!tick_out_a && w < 20) begin
            @(negedge clock);
            w++;
        end
        chk("sync_tick", 64'(tick_out_a), 64'd1);
    endtask

    task automatic settle();
        repeat (3) @(negedge clock);
    endtask

    initial begin
        reset = 1'b1;
        addr  = 12'd21;
        wren  = 1'b0;
        wdata = 32'd0;
        repeat (2) @(negedge clock);
        chk("rst_duty", 64'(duty_a), 64'({10'd512, 10'd512, 10'd512}));
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_rd_data", 64'(bus_a.rd_data), 64'd0);
        chk("rst_tick_out", 64'(tick_out_a), 64'd0);
        reset = 1'b0;

        // Ramp up by 4 per tick
        bus_write(12'd20, 32'd4);
        bus_write(12'd11, 32'd520);
        chk("ramp_busy0_set", 64'(busy_a[0]), 64'd1);
        sync_tick(); settle();
        chk("ramp_cur0_t1", 64'(duty_a[9:0]), 64'd516);
        sync_tick(); settle();
        chk("ramp_cur0_t2", 64'(duty_a[9:0]), 64'd520);
        chk("ramp_busy0_clr", 64'(busy_a[0]), 64'd0);
        chk("ramp_ch12_hold", 64'(duty_a[29:10]), 64'({10'd512, 10'd512}));

        // Down-ramp with a final partial step, then step-0 snap
        bus_write(12'd20, 32'd10);
        bus_write(12'd12, 32'd505);
        sync_tick(); settle();
        chk("down_cur1", 64'(duty_a[19:10]), 64'd505);
        bus_write(12'd13, 32'd1023);
        bus_write(12'd20, 32'd0);
        sync_tick(); settle();
        chk("snap_cur2", 64'(duty_a[29:20]), 64'd1023);

        // Clamp on the narrow instance (50..100); its ch0 already sits at 100
        bus_write(12'd11, 32'h0000_0FFF);
        chk("clamp_hi_b_idle", 64'(busy_b[0]), 64'd0);
        chk("clamp_hi_a_busy", 64'(busy_a[0]), 64'd1);
        bus_write(12'd11, 32'd3);
        chk("clamp_lo_b_busy", 64'(busy_b[0]), 64'd1);
        sync_tick(); settle();
        chk("clamp_lo_b_cur0", 64'(duty_b[9:0]), 64'd50);
        chk("clamp_lo_a_cur0", 64'(duty_a[9:0]), 64'd3);

        // Collision: target write lands in the UPD0 cycle of ch0
        bus_write(12'd11, 32'd512);
        sync_tick(); settle();
        chk("coll_prep", 64'(duty_a[9:0]), 64'd512);
        bus_write(12'd20, 32'd4);
        sync_tick();
        bus_write(12'd11, 32'd600);
        chk("coll_hold", 64'(duty_a[9:0]), 64'd512);
        chk("coll_busy", 64'(busy_a[0]), 64'd1);
        sync_tick(); settle();
        chk("coll_next", 64'(duty_a[9:0]), 64'd516);

        // Reset mid-ramp
        bus_write(12'd11, 32'd700);
        repeat (6) begin
            sync_tick(); settle();
        end
        chk("midramp_cur0", 64'(duty_a[9:0]), 64'd540);
        reset = 1'b1;
        @(negedge clock);
        chk("mrst_duty", 64'(duty_a), 64'({10'd512, 10'd512, 10'd512}));
        chk("mrst_busy", 64'(busy_a), 64'd0);
        chk("mrst_state", 64'(dut_a.state), 64'(IDLE));
        chk("mrst_cnt", 64'(dut_a.u_tick.cnt), 64'd0);
        chk("mrst_rd_data", 64'(bus_a.rd_data), 64'd0);
        reset = 1'b0;
        repeat (8) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
